mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency memory between the instruction-fetch port (IF) and the data port (MEM stage).
- Grants one access at a time and tracks the in-flight access with a latency counter.
- Returns read data and a completion pulse to the owning port.
- Drives the stall signals that the pipeline registers use to hold IF and MEM while they wait.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port (IF) and the data port (D). Only one access is in flight at a time, and
// a latency counter tracks it. When the access completes, the owning port gets
// a one-cycle Valid pulse and its read data. The block also drives the stall
// signals that hold the pipeline while a port waits.
//
// Build option: define ARB_FAIR_EN to alternate grants under contention.
// When it is undefined, data requests always beat fetch requests.

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1      // legal range 1..4
) (
  input  logic              clock,
  input  logic              reset,
  // instruction-fetch port
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifValid,
  output logic [DATA_W-1:0] ifRdata,
  // data port
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dValid,
  output logic [DATA_W-1:0] dRdata,
  // memory side
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  // pipeline stalls
  output logic              stallIF,
  output logic              stallMEM
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_d_we;       // the in-flight D access is a store
  logic [DATA_W-1:0]  r_if_rdata;
  logic [DATA_W-1:0]  r_d_rdata;

  logic w_if_done;
  logic w_d_done;
  logic w_if_req;
  logic w_d_req;
  logic w_eligible;
  logic w_issue;
  logic w_grant_d;

  // The completion cycle is the BUSY cycle in which the counter has run out.
  assign w_if_done = (r_state == BUSY_IF) && (r_cnt == '0);
  assign w_d_done  = (r_state == BUSY_D)  && (r_cnt == '0);

  // A port that completes in this cycle must not be granted again right away.
  assign w_if_req = ifReq & ~w_if_done;
  assign w_d_req  = dReq  & ~w_d_done;

  // Gating with reset keeps memEn low while reset is held. Otherwise a request
  // that is already high would show up combinationally during reset.
  assign w_eligible = ~reset & ((r_state == IDLE) | w_if_done | w_d_done);
  assign w_issue    = w_eligible & (w_if_req | w_d_req);

`ifdef ARB_FAIR_EN
  logic r_last_d;

  // IF wins a tie only when the previous grant went to D.
  assign w_grant_d = w_d_req & ~(w_if_req & r_last_d);

  // Record which port was granted last, so that ties alternate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_last_d <= 1'b0;
    else if (w_issue) r_last_d <= w_grant_d;
  end
`else
  assign w_grant_d = w_d_req;
`endif

  // Memory issue strobe. When nothing is issued, address and data are forced to 0.
  assign memEn    = w_issue;
  assign memWe    = w_issue & w_grant_d & dWe;
  assign memAddr  = w_issue ? (w_grant_d ? dAddr : ifAddr) : '0;
  assign memWdata = (w_issue & w_grant_d) ? dWdata : '0;

  // Completion: forward memRdata in the Valid cycle. Otherwise show the held copy.
  assign ifValid = w_if_done;
  assign dValid  = w_d_done;
  assign ifRdata = w_if_done ? memRdata : r_if_rdata;
  assign dRdata  = (w_d_done && !r_d_we) ? memRdata : r_d_rdata;

  assign stallIF  = ifReq & ~ifValid;
  assign stallMEM = dReq  & ~dValid;

  // Ownership FSM and latency counter. The owner is encoded in the state.
  // NOTE: sequential state is updated only with non-blocking assignments in a
  // clocked block. This way every flop samples the values from before the
  // edge, no matter how the blocks are ordered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_d_we  <= 1'b0;
    end else if (w_issue) begin
      r_state <= w_grant_d ? BUSY_D : BUSY_IF;
      r_cnt   <= CNT_W'(MEM_LAT - 1);
      r_d_we  <= w_grant_d & dWe;
    end else if (w_if_done || w_d_done) begin
      r_state <= IDLE;
    end else if (r_state != IDLE) begin
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Hold the last read data for each port until that port's next load completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_done)            r_if_rdata <= memRdata;
      if (w_d_done && !r_d_we)  r_d_rdata  <= memRdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Three DUTs run side by side, with MEM_LAT = 1, 2 and 3. Each DUT has its own
// memory model, a directed script with literal expectations, and a
// transaction-level model that is compared against the DUT on every falling edge.

module tb_mem_port_arbiter;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  task automatic check(input string name, input int lat,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lat%0d %s: got %h expected %h", lat, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int LAT = g + 1;

    logic        reset, ifReq, ifValid, dReq, dWe, dValid;
    logic        memEn, memWe, stallIF, stallMEM;
    logic [31:0] ifAddr, ifRdata, dAddr, dWdata, dRdata;
    logic [31:0] memAddr, memWdata, memRdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clock(clk), .reset(reset),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifValid(ifValid), .ifRdata(ifRdata),
      .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
      .dValid(dValid), .dRdata(dRdata),
      .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memRdata(memRdata),
      .stallIF(stallIF), .stallMEM(stallMEM)
    );

    // Memory model: word array indexed by addr[9:2]. Read data is correct only
    // exactly LAT cycles after issue; in every other cycle it is the inverted word.
    logic [31:0] mem [0:255];
    int          cyc = 0;
    int          iss_cyc = 0;
    logic [7:0]  iss_idx = '0;
    bit          iss_v = 1'b0;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 + i;
      mem[8'h10] = 32'h00A0_0093;   // 0x40
      mem[8'h11] = 32'hCAFE_0044;   // 0x44
      mem[8'h40] = 32'h1234_5678;   // 0x100
    end

    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (memEn) begin
        iss_v   <= 1'b1;
        iss_cyc <= cyc;
        iss_idx <= memAddr[9:2];
        if (memWe) mem[memAddr[9:2]] <= memWdata;
      end
    end

    assign memRdata = (iss_v && cyc == iss_cyc + LAT) ? mem[iss_idx] : ~mem[iss_idx];

    // Transaction model: one access in flight, which completes at an absolute cycle number.
    int          m_owner = 0;        // 0 none, 1 IF, 2 D
    int          m_done  = 0;
    logic [7:0]  m_idx   = '0;
    bit          m_store = 1'b0;
    bit          m_last_d = 1'b0;
    logic [31:0] m_if_data = '0;
    logic [31:0] m_d_data  = '0;

    always @(negedge clk) begin : model
      bit          done_if, done_d, free, ri, rd, win_d, issue;
      logic [31:0] e_addr, e_if, e_d;
      if (reset) begin
        m_owner = 0; m_last_d = 1'b0; m_if_data = '0; m_d_data = '0;
        check("reset ifValid", LAT, 32'(ifValid), 32'd0);
        check("reset dValid",  LAT, 32'(dValid),  32'd0);
        check("reset memEn",   LAT, 32'(memEn),   32'd0);
        check("reset memWe",   LAT, 32'(memWe),   32'd0);
        check("reset ifRdata", LAT, ifRdata, 32'd0);
        check("reset dRdata",  LAT, dRdata,  32'd0);
      end else begin
        done_if = (m_owner == 1) && (cyc == m_done);
        done_d  = (m_owner == 2) && (cyc == m_done);
        free    = (m_owner == 0) || done_if || done_d;
        ri      = ifReq && !done_if;
        rd      = dReq  && !done_d;
        win_d   = rd && !(FAIR && ri && m_last_d);
        issue   = free && (ri || rd);
        e_addr  = issue ? (win_d ? dAddr : ifAddr) : 32'd0;
        e_if    = done_if ? mem[m_idx] : m_if_data;
        e_d     = (done_d && !m_store) ? mem[m_idx] : m_d_data;

        check("ifValid",  LAT, 32'(ifValid),  32'(done_if));
        check("dValid",   LAT, 32'(dValid),   32'(done_d));
        check("memEn",    LAT, 32'(memEn),    32'(issue));
        check("memWe",    LAT, 32'(memWe),    32'(issue && win_d && dWe));
        check("memAddr",  LAT, memAddr, e_addr);
        check("ifRdata",  LAT, ifRdata, e_if);
        check("dRdata",   LAT, dRdata,  e_d);
        check("stallIF",  LAT, 32'(stallIF),  32'(ifReq && !done_if));
        check("stallMEM", LAT, 32'(stallMEM), 32'(dReq && !done_d));
        if (issue && win_d) check("memWdata", LAT, memWdata, dWdata);

        if (done_if) m_if_data = mem[m_idx];
        if (done_d && !m_store) m_d_data = mem[m_idx];
        if (done_if || done_d) m_owner = 0;
        if (issue) begin
          m_owner  = win_d ? 2 : 1;
          m_done   = cyc + LAT;
          m_idx    = win_d ? dAddr[9:2] : ifAddr[9:2];
          m_store  = win_d && dWe;
          m_last_d = win_d;
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    // Counts falling edges until the chosen Valid pulse is seen; the count is bounded.
    task automatic wait_valid(input bit on_d, output int n);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(on_d ? dValid : ifValid) && n < 50);
    endtask

    initial begin : stim
      int n, gi, gd, pulses;
      reset = 1'b1; ifReq = 1'b0; ifAddr = '0;
      dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
      repeat (2) @(posedge clk);
      step(); reset = 1'b0;

      // Single fetch: issue happens in cycle 0 and Valid comes LAT cycles later.
      step(); ifReq = 1'b1; ifAddr = 32'h40;
      @(negedge clk);
      check("fetch issue memEn", LAT, 32'(memEn), 32'd1);
      check("fetch issue addr",  LAT, memAddr, 32'h40);
      check("fetch stallIF c0",  LAT, 32'(stallIF), 32'd1);
      wait_valid(1'b0, n);
      check("fetch latency",     LAT, n, LAT);
      check("fetch data",        LAT, ifRdata, 32'h00A0_0093);
      check("no reissue memEn",  LAT, 32'(memEn), 32'd0);
      check("fetch stallIF done", LAT, 32'(stallIF), 32'd0);
      step(); ifReq = 1'b0;
      @(negedge clk);
      check("ifRdata held",      LAT, ifRdata, 32'h00A0_0093);

      // Both ports request together in IDLE: D is served first, then IF back-to-back.
      step(); ifReq = 1'b1; ifAddr = 32'h44; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h100;
      @(negedge clk);
      check("contend first addr", LAT, memAddr, 32'h100);
      wait_valid(1'b1, n);
      check("load latency",      LAT, n, LAT);
      check("load data",         LAT, dRdata, 32'h1234_5678);
      check("b2b IF issue",      LAT, 32'(memEn), 32'd1);
      check("b2b IF addr",       LAT, memAddr, 32'h44);
      check("IF still stalled",  LAT, 32'(stallIF), 32'd1);
      step(); dReq = 1'b0;
      wait_valid(1'b0, n);
      check("queued fetch wait", LAT, n, LAT);
      check("queued fetch data", LAT, ifRdata, 32'hCAFE_0044);
      step(); ifReq = 1'b0;

      // Store: a one-cycle write strobe is issued and dRdata keeps the previous load value.
      step(); dReq = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("store memWe",       LAT, 32'(memWe), 32'd1);
      check("store memAddr",     LAT, memAddr, 32'h200);
      check("store memWdata",    LAT, memWdata, 32'hDEAD_BEEF);
      wait_valid(1'b1, n);
      check("store latency",     LAT, n, LAT);
      check("store dRdata kept", LAT, dRdata, 32'h1234_5678);
      step(); dReq = 1'b0; dWe = 1'b0;
      step(); dReq = 1'b1; dAddr = 32'h200;
      @(negedge clk);
      wait_valid(1'b1, n);
      check("load back",         LAT, dRdata, 32'hDEAD_BEEF);
      step(); dReq = 1'b0;

      // Continuous contention that starts from IDLE just after a D grant.
      step();
      step(); ifReq = 1'b1; ifAddr = 32'h48; dReq = 1'b1; dAddr = 32'h104;
      gi = 0; gd = 0;
      @(negedge clk);
      check("tie first grant",   LAT, memAddr, FAIR ? 32'h48 : 32'h104);
      if (memEn) begin if (memAddr == 32'h104) gd++; else gi++; end
      repeat (4 * LAT - 1) begin
        @(negedge clk);
        if (memEn) begin if (memAddr == 32'h104) gd++; else gi++; end
      end
      check("contend D grants",  LAT, gd, 2);
      check("contend IF grants", LAT, gi, 2);
      step(); ifReq = 1'b0; dReq = 1'b0;
      repeat (2 * LAT + 2) step();

      // Reset one cycle after issue: outputs clear at once and no Valid pulse follows.
      step(); ifReq = 1'b1; ifAddr = 32'h4C;
      step(); reset = 1'b1; ifReq = 1'b0;
      #1;
      check("async rst ifValid", LAT, 32'(ifValid), 32'd0);
      check("async rst memEn",   LAT, 32'(memEn), 32'd0);
      check("async rst ifRdata", LAT, ifRdata, 32'd0);
      check("async rst dRdata",  LAT, dRdata, 32'd0);
      step(); reset = 1'b0;
      pulses = 0;
      repeat (2 * LAT + 2) begin
        @(negedge clk);
        if (ifValid || dValid) pulses++;
      end
      check("no pulse after rst", LAT, pulses, 0);
      step(); ifReq = 1'b1; ifAddr = 32'h40;
      @(negedge clk);
      check("post-rst issue",    LAT, 32'(memEn), 32'd1);
      wait_valid(1'b0, n);
      check("post-rst latency",  LAT, n, LAT);
      check("post-rst data",     LAT, ifRdata, 32'h00A0_0093);
      step(); ifReq = 1'b0;
      repeat (3) step();
      n_done++;
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      @(posedge clk);
      if (n_done == 3) break;
    end
    if (n_done != 3) begin
      checks++;
      errors++;
      $display("FAIL global timeout: %0d of 3 scripts finished, expected 3", n_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
